// File: rtl/rv_muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package rv_muldiv_pkg;

    localparam int MULDIV_ITER = 32;
    localparam int CNT_W       = $clog2(MULDIV_ITER);

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } muldiv_state_t;

    function automatic logic isDivOp(input muldiv_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic isRemOp(input muldiv_op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/rv_muldiv_step.sv
// One iteration of the shared 33-bit add/sub datapath: shift-add multiply
// (LSB first) or restoring divide (MSB first) over the {hi, lo} register pair.
module rv_muldiv_step (
    input  logic        div_i,
    input  logic [32:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic [31:0] b_i,
    output logic [32:0] hi_o,
    output logic [31:0] lo_o
);

    logic [32:0] addA;
    logic [32:0] addB;
    logic [32:0] sum;
    logic [32:0] mulT;
    logic        qBit;

    // Divide subtracts the divisor from the shifted remainder; multiply adds the
    // multiplicand into the upper half. A divide result that stays non-negative
    // always fits in 32 bits, so bit 32 of the sum is its sign.
    always_comb begin
        addA = div_i ? {hi_i[31:0], lo_i[31]} : hi_i;
        addB = div_i ? ~{1'b0, b_i} : {1'b0, b_i};
        sum  = addA + addB + {32'd0, div_i};
        qBit = ~sum[32];
        mulT = lo_i[0] ? sum : hi_i;
        if (div_i) begin
            hi_o = qBit ? sum : addA;
            lo_o = {lo_i[30:0], qBit};
        end else begin
            hi_o = {1'b0, mulT[32:1]};
            lo_o = {mulT[0], lo_i[31:1]};
        end
    end

endmodule

// File: rtl/rv_muldiv_seq.sv
// RV32M iterative sequencer: latches one M-extension op, iterates 32 times on
// unsigned magnitudes, fixes the sign, then strobes the result for one cycle.
module rv_muldiv_seq
    import rv_muldiv_pkg::*;
#(
    parameter bit ENABLE_DIV   = 1'b1,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_flush,
    input  logic        i_valid,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_op1,
    input  logic [31:0] i_op2,
    input  logic [4:0]  i_rd,
    output logic        o_busy,
    output logic        o_valid,
    output logic [31:0] o_result,
    output logic [4:0]  o_rd
);

    muldiv_state_t    state_q, state_d;
    muldiv_op_t       op_q, opIn;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       rd_q;
    logic             neg_q;
    logic [32:0]      hi_q, stepHi;
    logic [31:0]      lo_q, b_q, stepLo;
    logic [31:0]      result_q;

    logic             aNeg, bNeg, divOpIn, divZero, divOvf, special, negIn, accept, stepDiv;
    logic [31:0]      aMag, bMag, specialRes, fixRes, quoFix, remFix;
    logic [63:0]      prod, prodFix;

    always_comb begin
        opIn    = muldiv_op_t'(i_funct3);
        aNeg    = i_op1[31] && (opIn inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        bNeg    = i_op2[31] && (opIn inside {OP_MULH, OP_DIV, OP_REM});
        aMag    = aNeg ? (~i_op1 + 32'd1) : i_op1;
        bMag    = bNeg ? (~i_op2 + 32'd1) : i_op2;
        divOpIn = ENABLE_DIV && isDivOp(opIn);
        divZero = (i_op2 == 32'd0);
        divOvf  = (opIn inside {OP_DIV, OP_REM}) && (i_op1 == 32'h8000_0000) && (i_op2 == 32'hFFFF_FFFF);
        special = FAST_SPECIAL && divOpIn && (divZero || divOvf);
        if (divZero) begin
            specialRes = isRemOp(opIn) ? i_op1 : 32'hFFFF_FFFF;
        end else begin
            specialRes = isRemOp(opIn) ? 32'd0 : 32'h8000_0000;
        end
        // Quotient sign is suppressed for x/0 so the slow path still yields all-ones.
        if (!isDivOp(opIn)) begin
            negIn = aNeg ^ bNeg;
        end else if (isRemOp(opIn)) begin
            negIn = aNeg;
        end else begin
            negIn = (aNeg ^ bNeg) && !divZero;
        end
        accept  = (state_q == ST_IDLE) && i_valid && !i_flush;
        stepDiv = ENABLE_DIV && isDivOp(op_q);
    end

    rv_muldiv_step u_step (
        .div_i (stepDiv),
        .hi_i  (hi_q),
        .lo_i  (lo_q),
        .b_i   (b_q),
        .hi_o  (stepHi),
        .lo_o  (stepLo)
    );

    always_comb begin
        prod    = {hi_q[31:0], lo_q};
        prodFix = neg_q ? (~prod + 64'd1) : prod;
        quoFix  = neg_q ? (~lo_q + 32'd1) : lo_q;
        remFix  = neg_q ? (~hi_q[31:0] + 32'd1) : hi_q[31:0];
        case (op_q)
            OP_MUL:                       fixRes = prodFix[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fixRes = prodFix[63:32];
            OP_DIV, OP_DIVU:              fixRes = ENABLE_DIV ? quoFix : 32'd0;
            default:                      fixRes = ENABLE_DIV ? remFix : 32'd0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (i_valid) state_d = special ? ST_DONE : ST_CALC;
                ST_CALC: if (cnt_q == '0) state_d = ST_FIX;
                ST_FIX:  state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy  = ((state_q == ST_IDLE) && i_valid) || (state_q == ST_CALC) || (state_q == ST_FIX);
        o_valid = (state_q == ST_DONE) && !i_flush;
    end

    // Multiply and divide both start from hi=0, lo=|op1|, b=|op2|.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            op_q     <= OP_MUL;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q  <= opIn;
            rd_q  <= i_rd;
            neg_q <= negIn;
            cnt_q <= CNT_W'(MULDIV_ITER - 1);
            hi_q  <= '0;
            lo_q  <= aMag;
            b_q   <= bMag;
            if (special) begin
                result_q <= specialRes;
            end
        end else if ((state_q == ST_CALC) && !i_flush) begin
            hi_q  <= stepHi;
            lo_q  <= stepLo;
            cnt_q <= cnt_q - CNT_W'(1);
        end else if ((state_q == ST_FIX) && !i_flush) begin
            result_q <= fixRes;
        end
    end

    assign o_result = result_q;
    assign o_rd     = rd_q;

endmodule

// File: tb/tb_rv_muldiv_seq.sv
// Self-checking bench for rv_muldiv_seq: RV32M arithmetic reference model plus
// a latency countdown, compared every cycle, with directed literal checks.
module tb_rv_muldiv_seq;
    import rv_muldiv_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset, i_flush, i_valid;
    logic [2:0]  i_funct3;
    logic [31:0] i_op1, i_op2;
    logic [4:0]  i_rd;
    logic        o_busy, o_valid;
    logic [31:0] o_result;
    logic [4:0]  o_rd;

    int          total = 0;
    int          bad = 0;
    int          mCnt = 0;
    int          mAccepts = 0;
    logic [31:0] mRes = '0;
    logic [4:0]  mRd = '0;
    bit          checking = 1'b0;
    logic        expValid, expBusy;

    rv_muldiv_seq #(
        .ENABLE_DIV   (1'b1),
        .FAST_SPECIAL (1'b1)
    ) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_flush  (i_flush),
        .i_valid  (i_valid),
        .i_funct3 (i_funct3),
        .i_op1    (i_op1),
        .i_op2    (i_op2),
        .i_rd     (i_rd),
        .o_busy   (o_busy),
        .o_valid  (o_valid),
        .o_result (o_result),
        .o_rd     (o_rd)
    );

    always #5 i_clk = ~i_clk;

    // RV32M semantics straight from 64-bit products and native signed division.
    function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int          ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        p  = '0;
        case (f)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 32'd0)) return 1;
        if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // mCnt counts down the cycles until the strobe; zero means ready to accept.
    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            mCnt = 0;
        end else if (i_flush) begin
            mCnt = 0;
        end else if (mCnt == 0) begin
            if (i_valid) begin
                mCnt = refLatency(i_funct3, i_op1, i_op2);
                mRes = refModel(i_funct3, i_op1, i_op2);
                mRd  = i_rd;
                mAccepts++;
            end
        end else begin
            mCnt--;
        end
    end

    always @(negedge i_clk) begin
        if (checking) begin
            expValid = (mCnt == 1) && !i_flush;
            expBusy  = (mCnt == 0) ? i_valid : (mCnt > 1);
            checkOutput("o_valid", 32'(o_valid), 32'(expValid));
            checkOutput("o_busy", 32'(o_busy), 32'(expBusy));
            if (expValid) begin
                checkOutput("o_result", o_result, mRes);
                checkOutput("o_rd", 32'(o_rd), 32'(mRd));
            end
        end
    end

    task automatic waitValid(output int lat);
        bit found;
        found = 1'b0;
        lat   = 0;
        while (!found && lat < 100) begin
            lat++;
            @(negedge i_clk);
            if (o_valid) begin
                found = 1'b1;
            end else begin
                @(posedge i_clk);
                #1;
            end
        end
        checkOutput("valid_seen", 32'(found), 32'd1);
    endtask

    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic [31:0] expRes, input int expLat,
                                 input string name);
        int lat;
        @(posedge i_clk);
        #1;
        i_valid  = 1'b1;
        i_funct3 = f3;
        i_op1    = a;
        i_op2    = b;
        i_rd     = rd;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        waitValid(lat);
        checkOutput({name, "_result"}, o_result, expRes);
        checkOutput({name, "_rd"}, 32'(o_rd), 32'(rd));
        checkOutput({name, "_latency"}, 32'(lat), 32'(expLat));
    endtask

    initial begin
        int lat, startAcc, waited, gap;
        i_reset  = 1'b1;
        i_flush  = 1'b0;
        i_valid  = 1'b0;
        i_funct3 = '0;
        i_op1    = '0;
        i_op2    = '0;
        i_rd     = '0;
        repeat (2) @(posedge i_clk);
        #1;
        checkOutput("reset_valid", 32'(o_valid), 32'd0);
        checkOutput("reset_busy", 32'(o_busy), 32'd0);
        checkOutput("reset_result", o_result, 32'd0);
        checkOutput("reset_rd", 32'(o_rd), 32'd0);
        i_reset  = 1'b0;
        checking = 1'b1;

        applyStimulus(OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFEB, 34, "mul_7xm3");
        applyStimulus(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFE, 34, "mulhu_max");
        applyStimulus(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, 34, "mulh_m1");
        applyStimulus(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'hFFFF_FFFF, 34, "mulhsu_m1");
        applyStimulus(OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd15, 32'hFFFF_FFFD, 34, "div_m7_2");
        applyStimulus(OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd16, 32'hFFFF_FFFF, 34, "rem_m7_2");
        applyStimulus(OP_DIVU,   32'd100,       32'd7,         5'd17, 32'd14,        34, "divu_100_7");
        applyStimulus(OP_REMU,   32'd100,       32'd7,         5'd18, 32'd2,         34, "remu_100_7");
        applyStimulus(OP_DIV,    32'h0000_1234, 32'd0,         5'd19, 32'hFFFF_FFFF, 1,  "div_by0");
        applyStimulus(OP_REM,    32'h0000_1234, 32'd0,         5'd20, 32'h0000_1234, 1,  "rem_by0");
        applyStimulus(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h8000_0000, 1,  "div_ovf");
        applyStimulus(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h0000_0000, 1,  "rem_ovf");

        // Abort a multiply ten iterations in, then run a fresh one.
        @(posedge i_clk);
        #1;
        i_valid  = 1'b1;
        i_funct3 = OP_MUL;
        i_op1    = 32'h0000_0AAA;
        i_op2    = 32'h0000_0555;
        i_rd     = 5'd9;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (10) @(posedge i_clk);
        #1;
        i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        @(negedge i_clk);
        checkOutput("flush_busy", 32'(o_busy), 32'd0);
        checkOutput("flush_valid", 32'(o_valid), 32'd0);
        applyStimulus(OP_MUL, 32'd12345, 32'd678, 5'd3, 32'd8369910, 34, "mul_after_flush");

        // Asynchronous reset in the middle of an iteration.
        @(posedge i_clk);
        #1;
        i_valid  = 1'b1;
        i_funct3 = OP_MUL;
        i_op1    = 32'h0000_1111;
        i_op2    = 32'h0000_2222;
        i_rd     = 5'd17;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (5) @(posedge i_clk);
        #3;
        i_reset = 1'b1;
        #1;
        checkOutput("midreset_valid", 32'(o_valid), 32'd0);
        checkOutput("midreset_busy", 32'(o_busy), 32'd0);
        checkOutput("midreset_result", o_result, 32'd0);
        checkOutput("midreset_rd", 32'(o_rd), 32'd0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;

        // Back-to-back with the request held high across DONE.
        @(posedge i_clk);
        #1;
        i_valid  = 1'b1;
        i_funct3 = OP_DIVU;
        i_op1    = 32'd1000;
        i_op2    = 32'd10;
        i_rd     = 5'd4;
        @(posedge i_clk);
        #1;
        waitValid(lat);
        checkOutput("b2b_first_result", o_result, 32'd100);
        checkOutput("b2b_first_latency", 32'(lat), 32'd34);
        checkOutput("b2b_done_busy", 32'(o_busy), 32'd0);
        #1;
        i_funct3 = OP_REMU;
        i_op1    = 32'd1000;
        i_op2    = 32'd7;
        i_rd     = 5'd5;
        @(posedge i_clk);
        #1;
        checkOutput("b2b_idle_busy", 32'(o_busy), 32'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        waitValid(lat);
        checkOutput("b2b_second_result", o_result, 32'd6);
        checkOutput("b2b_second_rd", 32'(o_rd), 32'd5);
        checkOutput("b2b_second_latency", 32'(lat), 32'd34);

        // Random traffic with occasional flushes; the per-cycle compare does the checking.
        for (int n = 0; n < 80; n++) begin
            @(posedge i_clk);
            #1;
            i_funct3 = 3'($urandom_range(0, 7));
            i_op1    = randOperand();
            i_op2    = randOperand();
            i_rd     = 5'($urandom_range(0, 31));
            i_valid  = 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                i_flush = 1'b1;
                @(posedge i_clk);
                #1;
                i_flush = 1'b0;
            end
            startAcc = mAccepts;
            waited   = 0;
            while (mAccepts == startAcc && waited < 100) begin
                @(posedge i_clk);
                #1;
                waited++;
            end
            checkOutput("rand_accept", 32'(mAccepts != startAcc), 32'd1);
            if ($urandom_range(0, 1) == 1) begin
                i_valid = 1'b0;
                gap = $urandom_range(0, 45);
                for (int g = 0; g < gap; g++) begin
                    i_flush = ($urandom_range(0, 39) == 0);
                    @(posedge i_clk);
                    #1;
                end
                i_flush = 1'b0;
            end
        end
        i_valid = 1'b0;
        repeat (40) @(posedge i_clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
